// File: rtl/mem_rmw_ctrl_pkg.sv
// rtl/mem_rmw_ctrl_pkg.sv - op codes, FSM states and op-class helpers for mem_rmw_ctrl
package mem_rmw_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LBU = 4'd2,
    MEM_LH  = 4'd3,
    MEM_LHU = 4'd4,
    MEM_LW  = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  function automatic logic is_half_op(input logic [OP_W-1:0] op);
    return (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
  endfunction

  function automatic logic is_word_op(input logic [OP_W-1:0] op);
    return (op == MEM_LW) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_rmw_ctrl_if.sv
// rtl/mem_rmw_ctrl_if.sv - MEM-stage request and data-RAM bus bundle for mem_rmw_ctrl
interface mem_rmw_ctrl_if #(
  parameter int ADDR_W = 17
);
  logic              req_i;
  logic [3:0]        op_i;
  logic [31:0]       addr_i;
  logic [31:0]       wdata_i;
  logic              flush_i;
  logic [31:0]       rdata_o;
  logic              stall_o;
  logic              addr_err_o;
  logic              ram_ce_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_wdata_o;
  logic [31:0]       ram_rdata_i;

  modport slave (
    input  req_i, op_i, addr_i, wdata_i, flush_i, ram_rdata_i,
    output rdata_o, stall_o, addr_err_o, ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output req_i, op_i, addr_i, wdata_i, flush_i, ram_rdata_i,
    input  rdata_o, stall_o, addr_err_o, ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/mem_rmw_ctrl_lane_mux.sv
// rtl/mem_rmw_ctrl_lane_mux.sv - mem_lane_mux: big-endian load lane extract/extend and store lane merge
module mem_lane_mux
  import mem_rmw_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [1:0]        off_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [4:0]  byte_sh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unused_wdata;

  assign unused_wdata = ^wdata_i[31:16];

  always_comb begin
    // Offset 0 is the most significant byte, so shift by (3 - off) bytes.
    byte_sh  = {~off_i, 3'b000};
    byte_sel = 8'(word_i >> byte_sh);
    half_sel = off_i[1] ? word_i[15:0] : word_i[31:16];
    load_o   = '0;
    merge_o  = word_i;
    case (op_i)
      MEM_LB:  load_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: load_o = {24'd0, byte_sel};
      MEM_LH:  load_o = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: load_o = {16'd0, half_sel};
      MEM_LW:  load_o = word_i;
      MEM_SB:  merge_o = (word_i & ~(32'h0000_00ff << byte_sh)) | (32'(wdata_i[7:0]) << byte_sh);
      MEM_SH:  merge_o = off_i[1] ? {word_i[31:16], wdata_i[15:0]} : {wdata_i[15:0], word_i[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// rtl/mem_rmw_ctrl.sv - MEM-stage to word RAM controller with sub-word read-modify-write stores
// Optional misalignment detection: MEM_ALIGN_CHECK_EN.
module mem_rmw_ctrl
  import mem_rmw_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic          clk,
  input  logic          rst,
  mem_rmw_ctrl_if.slave bus
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   merge_q, merge_d;
  logic [DATA_W-1:0]   load_word;
  logic [DATA_W-1:0]   merged_word;
  logic                misalign;
  logic                unused_addr;

  assign unused_addr = ^bus.addr_i[31:ADDR_W+2];

  mem_lane_mux u_lane_mux (
    .op_i    (bus.op_i),
    .off_i   (bus.addr_i[1:0]),
    .word_i  (bus.ram_rdata_i),
    .wdata_i (bus.wdata_i),
    .load_o  (load_word),
    .merge_o (merged_word)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = bus.req_i &&
                    ((is_half_op(bus.op_i) && bus.addr_i[0]) ||
                     (is_word_op(bus.op_i) && (bus.addr_i[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign bus.ram_addr_o  = bus.addr_i[ADDR_W+1:2];
  assign bus.ram_wdata_o = (state_q == RMW_WR) ? merge_q : bus.wdata_i;

  always_comb begin
    state_d        = state_q;
    merge_d        = merge_q;
    bus.ram_ce_o   = 1'b0;
    bus.ram_we_o   = 1'b0;
    bus.stall_o    = 1'b0;
    bus.addr_err_o = 1'b0;
    bus.rdata_o    = '0;
    // Outputs are forced quiet while reset is held, even though they are combinational.
    if (rst && !bus.flush_i) begin
      case (state_q)
        IDLE: begin
          if (misalign) begin
            bus.addr_err_o = 1'b1;
          end else if (bus.req_i) begin
            case (bus.op_i)
              MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: begin
                bus.ram_ce_o = 1'b1;
                bus.rdata_o  = load_word;
              end
              MEM_SW: begin
                bus.ram_ce_o = 1'b1;
                bus.ram_we_o = 1'b1;
              end
              MEM_SB, MEM_SH: begin
                bus.ram_ce_o = 1'b1;
                bus.stall_o  = 1'b1;
                merge_d      = merged_word;
                state_d      = RMW_WR;
              end
              default: ;
            endcase
          end
        end
        RMW_WR: begin
          bus.ram_ce_o = 1'b1;
          bus.ram_we_o = 1'b1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
    end
  end

endmodule

// File: doc/mem_rmw_ctrl.md
# mem_rmw_ctrl

Memory-access controller between the MEM pipeline stage and the word-organised data RAM. It translates MEM-stage load/store requests into word-wide RAM accesses. It extracts and extends sub-word load data, and performs sub-word stores as a two-cycle read-modify-write, stalling the pipeline for one cycle. It also detects misaligned accesses.

## Interface
Parameters:
- ADDR_W, 17: RAM word-address width; equals the data RAM address bus width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset; one clock, all state clocked on rising clk
- req_i  in  1  MEM stage holds a valid memory instruction
- op_i  in  4  memory op code (encodings under Structure)
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-aligned
- flush_i  in  1  cancel current access (exception/flush)
- rdata_o  out  32  load result, extended, combinational
- stall_o  out  1  hold MEM stage and everything upstream
- addr_err_o  out  1  misaligned access (ALIGN_CHECK build only; else tied 0)
- ram_ce_o  out  1  RAM chip enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_W  RAM word address = addr_i[ADDR_W+1:2]
- ram_wdata_o  out  32  RAM write word
- ram_rdata_i  in  32  RAM read word (combinational, 0 while we=1)

## Operation
- Byte order is big-endian: byte offset 0 maps to bits 31:24 and offset 3 to bits 7:0. Halfword offset 0 maps to bits 31:16.
- FSM states:
  - IDLE: default state.
  - RMW_WR: write phase of a sub-word store.
- IDLE behaviour by op:
  - NOP, or req_i=0: ce=0, we=0, rdata_o=0, stall_o=0.
  - LB/LBU/LH/LHU/LW: ce=1, we=0. rdata_o is the selected lane: LB/LH sign-extended, LBU/LHU zero-extended, LW the full word. Single cycle, no stall.
  - SW: ce=1, we=1, ram_wdata_o=wdata_i. Single cycle, no stall.
  - SB/SH: ce=1, we=0 (read). Register the merged word: the read word with the addressed lane replaced by wdata_i[7:0] or wdata_i[15:0]. Assert stall_o=1. Next state is RMW_WR.
- RMW_WR behaviour:
  - Drive ce=1, we=1, ram_wdata_o = merged register, stall_o=0.
  - Next state is IDLE.
  - Inputs are still the held store and are ignored in this state.
- flush_i=1 in any state:
  - ce=0, we=0, stall_o=0, rdata_o=0.
  - Next state is IDLE and the merge register is not loaded.
  - The write is therefore suppressed even in RMW_WR.
- Misaligned access (ALIGN_CHECK build):
  - Condition: a halfword op with addr_i[0]=1, or a word op with addr_i[1:0]≠0.
  - Response: addr_err_o=1, ce=0, we=0, no stall, no state change.
- Undefined op codes are treated as NOP.

## Timing
- Reset values: state=IDLE, merge register=0.
- Reset-dependent outputs during reset: stall_o=0, ram_ce_o=0, ram_we_o=0, addr_err_o=0, rdata_o=0.
- Reset during RMW_WR returns to IDLE, and no write is issued after reset release.
- Latency:
  - Loads and SW: 0 extra cycles (data valid in the request cycle).
  - SB/SH: occupy 2 cycles, with exactly 1 stall cycle.
- stall_o is a combinational output of state and inputs, asserted only in IDLE for SB/SH with no flush and no misalignment.
- Back-to-back SB: the second SB is seen in IDLE on the cycle after RMW_WR, so the sequence is read, write, read, write.
- A load following an SB to the same word observes the written data, because the write commits at the end of RMW_WR.

## Configuration
- MEM_ALIGN_CHECK_EN defined: misalignment detection is active, addr_err_o is driven, and misaligned accesses are suppressed.
- MEM_ALIGN_CHECK_EN undefined: addr_err_o is tied 0.
  - Halfword ops ignore addr_i[0].
  - Word ops ignore addr_i[1:0].
  - The access proceeds at the truncated address.

## Structure
- defines.v holds the following constants:
  - Op codes: MEM_NOP=0, MEM_LB=1, MEM_LBU=2, MEM_LH=3, MEM_LHU=4, MEM_LW=5, MEM_SB=6, MEM_SH=7, MEM_SW=8.
  - FSM state encodings: IDLE=0, RMW_WR=1.
  - Width macros: OpBus 3:0; DataBus and DataAddrBus are reused.
- One combinational sub-module, mem_lane_mux, performs lane extraction/extension for loads and lane merge for stores. The FSM and registers stay in mem_rmw_ctrl.

## Test plan
- Preload word 4 (addr 0x10) with 0x8899AABB:
  - LB 0x10 -> rdata_o 0xFFFFFF88.
  - LBU 0x10 -> 0x00000088.
  - LHU 0x12 -> 0x0000AABB.
  - No stall on any of these.
- SB 0x13 with wdata 0x000000CC:
  - Cycle 1: stall_o=1, we=0.
  - Cycle 2: we=1 with ram_wdata_o=0x8899AACC.
  - Following LW 0x10 -> 0x8899AACC.
- SH 0x10 with 0x00001234 then SB 0x11 with 0x00000056, back-to-back:
  - Two stall cycles total.
  - Final word is 0x1256AACC.
- ALIGN_CHECK build:
  - LW 0x12 -> addr_err_o=1, ce=0, stall_o=0.
  - SH 0x11 -> addr_err_o=1, no write.
- SB issued, then flush_i=1 in the RMW_WR cycle -> we stays 0 and memory is unchanged.
- SB issued, then rst asserted asynchronously mid-RMW_WR -> outputs go 0 immediately, state is IDLE, memory is unchanged.
